turn_scheduler: RTL
===================

Name: turn_scheduler

Overview:
- Top-level game sequencer. Steps the game through its phases: MENU, PLAYER turn, ENEMY turn, RESULT.
- Issues start pulses to the phase modules and consumes their finished pulses.
- Commits phase changes only at a frame boundary, so the display never tears mid-frame.
- Owns the registered pixel mux that picks the active phase module's pixel stream for the display.

Parameters:
- V_ACTIVE, 720: first blanking line. A frame tick is hcount_in==0 && vcount_in==V_ACTIVE.
- WATCHDOG_FRAMES, 1800: frames a PLAYER or ENEMY turn may run before it is forcibly ended (30 s at 60 Hz).
- MAX_ROUNDS, 8: rounds before the game ends in a draw.

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  synchronous reset, active-high
- hcount_in  in  11  horizontal pixel count
- vcount_in  in  10  vertical line count
- start_btn_in  in  1  level from debounced button; edge-detected internally
- menu_finished_in  in  1  one-cycle pulse from menu module
- player_finished_in  in  1  one-cycle pulse from player module
- enemy_finished_in  in  1  one-cycle pulse from enemy module
- player_hp_zero_in  in  1  level: player defeated
- enemy_hp_zero_in  in  1  level: enemy defeated
- menu_pixel_in  in  12  RGB444 from menu
- player_pixel_in  in  12  RGB444 from player
- enemy_pixel_in  in  12  RGB444 from enemy
- phase_out  out  4  MENU 4'b0000, PLAYER 4'b0001, RESULT 4'b0010, ENEMY 4'b1000
- phase_start_out  out  1  one-cycle pulse on every phase commit
- round_out  out  4  completed PLAYER+ENEMY rounds
- winner_out  out  2  00 none, 01 player, 10 enemy, 11 draw
- pixel_out  out  12  registered RGB to display

Behaviour:
- Reset values:
  - phase_out=MENU, round_out=0, winner_out=00, pixel_out=0, phase_start_out=0, watchdog=0.
  - Internal state=WAIT_FRAME with pending=MENU, so the first frame tick emits the MENU start pulse.
- States:
  - RUN: current phase active.
  - WAIT_FRAME: next phase latched in pending; old phase still displayed.
- Commit (edge where WAIT_FRAME samples the frame tick true):
  - phase_out<=pending, phase_start_out<=1 for exactly one cycle, watchdog<=0, state<=RUN.
  - round_out increments on an ENEMY->PLAYER commit only.
- RUN transitions. Only the finished pulse matching phase_out is honoured; all others are ignored, as are all finished pulses in WAIT_FRAME.
  - MENU + menu_finished: pending=PLAYER, round_out<=0, winner_out<=00.
  - PLAYER + player_finished: enemy_hp_zero ? RESULT/winner 01 : ENEMY.
  - ENEMY + enemy_finished:
    - player_hp_zero ? RESULT/winner 10.
    - else round_out==MAX_ROUNDS-1 ? RESULT/winner 11.
    - else PLAYER.
  - Both hp_zero sampled on the same finished: RESULT, winner 11.
  - RESULT + rising edge of start_btn_in: pending=MENU. winner_out holds until the next menu_finished.
- Watchdog:
  - In RUN with phase PLAYER or ENEMY, counts frame ticks.
  - Reaching WATCHDOG_FRAMES behaves exactly as that phase's finished pulse that cycle.
  - A real finished pulse arriving in the same cycle is handled identically, with no double transition.
  - Not active in MENU or RESULT.
  - Saturates and does not wrap.
- Pixel mux: 1-cycle registered latency, selected by the current phase_out.
  - MENU->menu_pixel_in, PLAYER->player_pixel_in, ENEMY->enemy_pixel_in.
  - RESULT-> 12'h0F0 / 12'hF00 / 12'h888 for winner 01 / 10 / 11.
  - Any other code -> 12'h000.
- Reset mid-turn: all state returns to reset values on the next edge. Pending pulses are discarded.

Decomposition:
- Shared package game_pkg holds:
  - phase codes (enum, 4-bit);
  - winner codes;
  - RESULT colours.
- The enemy, menu and player modules import the same phase codes.
- Sub-module frame_watchdog: frame-tick detect plus saturating frame counter with clear, outputs expired.

Test Plan:
- Reset, then run frames: one phase_start_out pulse at the first tick (hcount 0, vcount 720); phase_out=0000; pixel_out follows menu_pixel_in one cycle late.
- menu_finished mid-frame: phase_out stays 0000 until the next frame tick, then becomes 0001 with one start pulse; round_out=0.
- Full round: player_finished then enemy_finished: phase goes 0001→1000→0001 on successive ticks; round_out=1.
- enemy_hp_zero high at player_finished: phase 0010, winner_out=01, pixel_out=12'h0F0. Start button rising edge then returns to 0000.
- With WATCHDOG_FRAMES=3, no finished in PLAYER: ENEMY is committed at the tick after the third counted tick. A finished pulse coincident with expiry yields a single transition.
- MAX_ROUNDS=2: second enemy_finished gives RESULT, winner 11. Both hp_zero at enemy_finished give 11. enemy_finished while in PLAYER is ignored.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: phase codes used by the scheduler and the
// menu/player/enemy modules, winner codes, scheduler FSM states and the
// solid colours shown on the RESULT screen.
package game_pkg;

  typedef enum logic [3:0] {
    PH_MENU   = 4'b0000,
    PH_PLAYER = 4'b0001,
    PH_RESULT = 4'b0010,
    PH_ENEMY  = 4'b1000
  } phase_e;

  typedef enum logic [1:0] {
    WIN_NONE   = 2'b00,
    WIN_PLAYER = 2'b01,
    WIN_ENEMY  = 2'b10,
    WIN_DRAW   = 2'b11
  } winner_e;

  typedef enum logic {
    ST_RUN        = 1'b0,
    ST_WAIT_FRAME = 1'b1
  } sched_state_e;

  localparam logic [11:0] COLOR_PLAYER_WIN = 12'h0F0;
  localparam logic [11:0] COLOR_ENEMY_WIN  = 12'hF00;
  localparam logic [11:0] COLOR_DRAW       = 12'h888;
  localparam logic [11:0] COLOR_BLANK      = 12'h000;

endpackage

// File: rtl/frame_watchdog.sv
// Frame-tick detector plus saturating frame counter for the turn watchdog.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   hcount_in       horizontal pixel count
//   vcount_in       vertical line count
//   enable_in       count frame ticks while high
//   clear_in        zero the counter (wins over counting)
//   frame_tick_out  first pixel of the first blanking line
//   expired_out     counter has reached WATCHDOG_FRAMES
module frame_watchdog #(
  parameter int V_ACTIVE        = 720,
  parameter int WATCHDOG_FRAMES = 1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        enable_in,
  input  logic        clear_in,
  output logic        frame_tick_out,
  output logic        expired_out
);

  localparam int CNT_W = $clog2(WATCHDOG_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WATCHDOG_FRAMES);

  logic [CNT_W-1:0] count_q, count_d;

  assign frame_tick_out = (hcount_in == 11'd0) && (vcount_in == 10'(V_ACTIVE));

  // Holds at CNT_MAX so a long-stalled turn keeps reporting expiry.
  always_comb begin
    count_d = count_q;
    if (clear_in) begin
      count_d = '0;
    end else if (enable_in && frame_tick_out && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_out = (count_q == CNT_MAX);

endmodule

// File: rtl/turn_scheduler.sv
// Top-level game sequencer: MENU -> PLAYER <-> ENEMY -> RESULT -> MENU.
// Phase changes are latched as pending and only committed on a frame tick
// so the display never switches source mid-frame.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   hcount_in, vcount_in     raster position (frame tick detection)
//   start_btn_in             debounced button level, rising edge used
//   *_finished_in            one-cycle done pulses from the phase modules
//   player/enemy_hp_zero_in  defeat levels sampled on a finished pulse
//   *_pixel_in               RGB444 streams from the phase modules
//   phase_out                committed phase code
//   phase_start_out          one-cycle pulse on each commit
//   round_out                completed PLAYER+ENEMY rounds
//   winner_out               00 none, 01 player, 10 enemy, 11 draw
//   pixel_out                registered RGB to the display
module turn_scheduler
  import game_pkg::*;
#(
  parameter int V_ACTIVE        = 720,
  parameter int WATCHDOG_FRAMES = 1800,
  parameter int MAX_ROUNDS      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        start_btn_in,
  input  logic        menu_finished_in,
  input  logic        player_finished_in,
  input  logic        enemy_finished_in,
  input  logic        player_hp_zero_in,
  input  logic        enemy_hp_zero_in,
  input  logic [11:0] menu_pixel_in,
  input  logic [11:0] player_pixel_in,
  input  logic [11:0] enemy_pixel_in,
  output logic [3:0]  phase_out,
  output logic        phase_start_out,
  output logic [3:0]  round_out,
  output logic [1:0]  winner_out,
  output logic [11:0] pixel_out
);

  localparam logic [3:0] LAST_ROUND = 4'(MAX_ROUNDS - 1);

  sched_state_e state_q, state_d;
  phase_e       phase_q, phase_d;
  phase_e       pending_q, pending_d;
  winner_e      winner_q, winner_d;
  logic [3:0]   round_q, round_d;
  logic         start_q, start_d;
  logic         btn_q, btn_d;
  logic [11:0]  pixel_q, pixel_d;

  logic frame_tick;
  logic wd_expired;
  logic in_turn;
  logic commit;
  logic phase_done;
  logic btn_rise;

  assign in_turn  = (state_q == ST_RUN) && ((phase_q == PH_PLAYER) || (phase_q == PH_ENEMY));
  assign commit   = (state_q == ST_WAIT_FRAME) && frame_tick;
  assign btn_rise = start_btn_in && !btn_q;

  frame_watchdog #(
    .V_ACTIVE        (V_ACTIVE),
    .WATCHDOG_FRAMES (WATCHDOG_FRAMES)
  ) u_watchdog (
    .clk            (clk),
    .rst            (rst),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .enable_in      (in_turn),
    .clear_in       (commit),
    .frame_tick_out (frame_tick),
    .expired_out    (wd_expired)
  );

  // Expiry is OR-ed with the real pulse, so a coincident pulse is one event.
  always_comb begin
    phase_done = 1'b0;
    case (phase_q)
      PH_MENU:   phase_done = menu_finished_in;
      PH_PLAYER: phase_done = player_finished_in || wd_expired;
      PH_ENEMY:  phase_done = enemy_finished_in || wd_expired;
      default:   phase_done = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    pending_d = pending_q;
    winner_d  = winner_q;
    round_d   = round_q;
    start_d   = 1'b0;
    btn_d     = start_btn_in;
    if (state_q == ST_WAIT_FRAME) begin
      if (frame_tick) begin
        phase_d = pending_q;
        start_d = 1'b1;
        state_d = ST_RUN;
        if ((phase_q == PH_ENEMY) && (pending_q == PH_PLAYER)) begin
          round_d = round_q + 4'd1;
        end
      end
    end else begin
      case (phase_q)
        PH_MENU: begin
          if (phase_done) begin
            pending_d = PH_PLAYER;
            round_d   = 4'd0;
            winner_d  = WIN_NONE;
            state_d   = ST_WAIT_FRAME;
          end
        end
        PH_PLAYER: begin
          if (phase_done) begin
            state_d = ST_WAIT_FRAME;
            if (player_hp_zero_in && enemy_hp_zero_in) begin
              pending_d = PH_RESULT;
              winner_d  = WIN_DRAW;
            end else if (enemy_hp_zero_in) begin
              pending_d = PH_RESULT;
              winner_d  = WIN_PLAYER;
            end else begin
              pending_d = PH_ENEMY;
            end
          end
        end
        PH_ENEMY: begin
          if (phase_done) begin
            state_d = ST_WAIT_FRAME;
            if (player_hp_zero_in && enemy_hp_zero_in) begin
              pending_d = PH_RESULT;
              winner_d  = WIN_DRAW;
            end else if (player_hp_zero_in) begin
              pending_d = PH_RESULT;
              winner_d  = WIN_ENEMY;
            end else if (round_q == LAST_ROUND) begin
              pending_d = PH_RESULT;
              winner_d  = WIN_DRAW;
            end else begin
              pending_d = PH_PLAYER;
            end
          end
        end
        PH_RESULT: begin
          if (btn_rise) begin
            pending_d = PH_MENU;
            state_d   = ST_WAIT_FRAME;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Pixel source follows the committed phase, never the pending one.
  always_comb begin
    pixel_d = COLOR_BLANK;
    case (phase_q)
      PH_MENU:   pixel_d = menu_pixel_in;
      PH_PLAYER: pixel_d = player_pixel_in;
      PH_ENEMY:  pixel_d = enemy_pixel_in;
      PH_RESULT: begin
        case (winner_q)
          WIN_PLAYER: pixel_d = COLOR_PLAYER_WIN;
          WIN_ENEMY:  pixel_d = COLOR_ENEMY_WIN;
          WIN_DRAW:   pixel_d = COLOR_DRAW;
          default:    pixel_d = COLOR_BLANK;
        endcase
      end
      default:   pixel_d = COLOR_BLANK;
    endcase
  end

  // Reset parks in WAIT_FRAME with MENU pending so the first tick starts MENU.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_WAIT_FRAME;
      phase_q   <= PH_MENU;
      pending_q <= PH_MENU;
      winner_q  <= WIN_NONE;
      round_q   <= 4'd0;
      start_q   <= 1'b0;
      btn_q     <= 1'b0;
      pixel_q   <= 12'h000;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      pending_q <= pending_d;
      winner_q  <= winner_d;
      round_q   <= round_d;
      start_q   <= start_d;
      btn_q     <= btn_d;
      pixel_q   <= pixel_d;
    end
  end

  assign phase_out       = phase_q;
  assign phase_start_out = start_q;
  assign round_out       = round_q;
  assign winner_out      = winner_q;
  assign pixel_out       = pixel_q;

endmodule
